// File: rtl/spu_odd_pkg.sv
// Shared types and default configuration for the SPU odd-pipe result tracker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spu_odd_pkg;

   // Default configuration: permute, local store and branch units
   localparam int ODD_DATA_W    = 128;
   localparam int ODD_ADDR_W    = 7;
   localparam int ODD_NUM_UNITS = 3;
   localparam int ODD_DEPTH     = 7;
   localparam int ODD_UNIT_W    = $clog2(ODD_NUM_UNITS);

   // Default per-unit result latencies, in cycles after issue
   localparam int ODD_LAT_PERM  = 4;
   localparam int ODD_LAT_LS    = 6;
   localparam int ODD_LAT_BR    = 1;

   // Execution unit numbering; the value is the index into res_valid/res_data
   typedef enum logic [ODD_UNIT_W-1:0] {
      UNIT_PERM = 2'd0,
      UNIT_LS   = 2'd1,
      UNIT_BR   = 2'd2
   } odd_unit_e;

   // One tracker stage for the default configuration
   typedef struct packed {
      logic                  valid;
      logic                  ready;
      logic                  wr;
      logic [ODD_UNIT_W-1:0] unit;
      logic [ODD_ADDR_W-1:0] addr;
      logic [ODD_DATA_W-1:0] data;
   } odd_stage_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/odd_result_stage.sv
// One tracker pipeline register: shifts the entry from the previous stage and merges unit results.
// Latency: 1 cycle, entry in stage STAGE-1 appears here after the next rising edge.
// Backpressure: none, the entry always advances; missing or misdirected results are flagged instead.
module odd_result_stage #(
   parameter int DATA_W    = 128,
   parameter int ADDR_W    = 7,
   parameter int NUM_UNITS = 3,
   parameter int UNIT_W    = 2,
   parameter int STAGE     = 1,
   parameter int LAT [NUM_UNITS] = '{4, 6, 1}
) (
   input  logic                        clock_i,
   input  logic                        reset_i,
   input  logic                        in_valid_i,
   input  logic                        in_ready_i,
   input  logic                        in_wr_i,
   input  logic [UNIT_W-1:0]           in_unit_i,
   input  logic [ADDR_W-1:0]           in_addr_i,
   input  logic [DATA_W-1:0]           in_data_i,
   input  logic [NUM_UNITS-1:0]        res_valid_i,
   input  logic [NUM_UNITS*DATA_W-1:0] res_data_i,
   output logic                        valid_o,
   output logic                        ready_o,
   output logic                        wr_o,
   output logic [UNIT_W-1:0]           unit_o,
   output logic [ADDR_W-1:0]           addr_o,
   output logic [DATA_W-1:0]           data_o,
   output logic                        mismatch_o,
   output logic                        missing_o
);

   typedef struct packed {
      logic              valid;
      logic              ready;
      logic              wr;
      logic [UNIT_W-1:0] unit;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } stage_t;

   stage_t stage_d;
   stage_t stage_q;

   // Next entry: copy the previous stage, then merge any unit whose result is due as it leaves STAGE-1
   always_comb begin
      stage_d    = '0;
      mismatch_o = 1'b0;
      missing_o  = 1'b0;
      if (in_valid_i) begin
         stage_d.valid = 1'b1;
         stage_d.ready = in_ready_i;
         stage_d.wr    = in_wr_i;
         stage_d.unit  = in_unit_i;
         stage_d.addr  = in_addr_i;
         stage_d.data  = in_data_i;
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (LAT[u] == STAGE - 1) begin
            if (in_valid_i && (in_unit_i == UNIT_W'(u))) begin
               if (res_valid_i[u]) begin
                  stage_d.data  = res_data_i[u*DATA_W +: DATA_W];
                  stage_d.ready = 1'b1;
               end else begin
                  // Result never arrived: retire the entry harmlessly so write-back stays safe
                  stage_d.wr    = 1'b0;
                  stage_d.ready = 1'b1;
                  stage_d.data  = '0;
                  missing_o     = 1'b1;
               end
            end else if (res_valid_i[u]) begin
               // Result with no matching entry at this point is dropped
               mismatch_o = 1'b1;
            end
         end
      end
   end

   // Stage register, cleared by reset so in-flight entries vanish
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign valid_o = stage_q.valid;
   assign ready_o = stage_q.ready;
   assign wr_o    = stage_q.wr;
   assign unit_o  = stage_q.unit;
   assign addr_o  = stage_q.addr;
   assign data_o  = stage_q.data;

endmodule

// File: rtl/odd_pipe_result_tracker.sv
// Odd-pipe result tracker: follows every issue for DEPTH stages, merges unit results, drives write-back.
// Latency: issue at cycle t reaches write-back at t+DEPTH; unit u result is due at t+LAT[u].
// Backpressure: none; stages never stall, protocol violations set sticky proto_err.
module odd_pipe_result_tracker
   import spu_odd_pkg::*;
#(
   parameter int DATA_W    = ODD_DATA_W,
   parameter int ADDR_W    = ODD_ADDR_W,
   parameter int NUM_UNITS = ODD_NUM_UNITS,
   parameter int DEPTH     = ODD_DEPTH,
   parameter int LAT [NUM_UNITS] = '{ODD_LAT_PERM, ODD_LAT_LS, ODD_LAT_BR},
   localparam int UNIT_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        issue_valid,
   input  logic [UNIT_W-1:0]           issue_unit,
   input  logic [ADDR_W-1:0]           issue_addr,
   input  logic                        issue_wr,
   input  logic                        issue_kill,
   input  logic [NUM_UNITS-1:0]        res_valid,
   input  logic [NUM_UNITS*DATA_W-1:0] res_data,
   output logic                        wb_valid,
   output logic [DATA_W-1:0]           wb_data,
   output logic [ADDR_W-1:0]           wb_reg_addr,
   output logic                        wb_enable_reg_write,
   output logic [DEPTH-1:0]            fwd_valid,
   output logic [DEPTH-1:0]            fwd_ready,
   output logic [DEPTH-1:0]            fwd_wr,
   output logic [DEPTH*ADDR_W-1:0]     fwd_addr,
   output logic [DEPTH*DATA_W-1:0]     fwd_data,
   output logic                        proto_err
);

   // Largest unit latency: length of the post-reset window in which stray results are ignored
   function automatic int lat_max();
      int m;
      m = 0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         m = max_int(m, LAT[u]);
      end
      return m;
   endfunction

   localparam int MAX_LAT = lat_max();
   localparam int GUARD_W = $clog2(MAX_LAT + 1);

   // Index 0 is the issue slot itself, 1..DEPTH are the registered stages
   logic [DEPTH:0]      st_valid;
   logic [DEPTH:0]      st_ready;
   logic [DEPTH:0]      st_wr;
   logic [UNIT_W-1:0]   st_unit [0:DEPTH];
   logic [ADDR_W-1:0]   st_addr [0:DEPTH];
   logic [DATA_W-1:0]   st_data [0:DEPTH];
   logic [DEPTH-1:0]    mismatch_vec;
   logic [DEPTH-1:0]    missing_vec;

   logic [GUARD_W-1:0]  guard_q;
   logic [GUARD_W-1:0]  guard_d;
   logic                proto_err_q;
   logic                proto_err_d;

   // A killed issue is still tracked so its result lands quietly, but it can never commit
   assign st_valid[0] = issue_valid;
   assign st_ready[0] = 1'b0;
   assign st_wr[0]    = issue_wr & ~issue_kill;
   assign st_unit[0]  = issue_unit;
   assign st_addr[0]  = issue_addr;
   assign st_data[0]  = '0;

   for (genvar s = 1; s <= DEPTH; s++) begin : g_stage
      odd_result_stage #(
         .DATA_W    (DATA_W),
         .ADDR_W    (ADDR_W),
         .NUM_UNITS (NUM_UNITS),
         .UNIT_W    (UNIT_W),
         .STAGE     (s),
         .LAT       (LAT)
      ) u_stage (
         .clock_i     (clock),
         .reset_i     (reset),
         .in_valid_i  (st_valid[s-1]),
         .in_ready_i  (st_ready[s-1]),
         .in_wr_i     (st_wr[s-1]),
         .in_unit_i   (st_unit[s-1]),
         .in_addr_i   (st_addr[s-1]),
         .in_data_i   (st_data[s-1]),
         .res_valid_i (res_valid),
         .res_data_i  (res_data),
         .valid_o     (st_valid[s]),
         .ready_o     (st_ready[s]),
         .wr_o        (st_wr[s]),
         .unit_o      (st_unit[s]),
         .addr_o      (st_addr[s]),
         .data_o      (st_data[s]),
         .mismatch_o  (mismatch_vec[s-1]),
         .missing_o   (missing_vec[s-1])
      );

      assign fwd_addr[(s-1)*ADDR_W +: ADDR_W] = st_addr[s];
      // Consumers only ever see final data
      assign fwd_data[(s-1)*DATA_W +: DATA_W] = st_ready[s] ? st_data[s] : '0;
   end

   assign fwd_valid = st_valid[DEPTH:1];
   assign fwd_ready = st_ready[DEPTH:1];
   assign fwd_wr    = st_wr[DEPTH:1];

   assign wb_valid            = st_valid[DEPTH];
   assign wb_data             = st_data[DEPTH];
   assign wb_reg_addr         = st_addr[DEPTH];
   assign wb_enable_reg_write = st_valid[DEPTH] & st_ready[DEPTH] & st_wr[DEPTH];

   // Guard countdown and sticky error: stray results are tolerated until the pipe has fully refilled
   always_comb begin
      guard_d     = (guard_q != '0) ? guard_q - GUARD_W'(1) : guard_q;
      proto_err_d = proto_err_q
                  | (|missing_vec)
                  | ((|mismatch_vec) & (guard_q == '0));
   end

   // Guard counter and error flag registers
   always_ff @(posedge clock) begin
      if (reset) begin
         guard_q     <= GUARD_W'(MAX_LAT);
         proto_err_q <= 1'b0;
      end else begin
         guard_q     <= guard_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_odd_pipe_result_tracker.sv
// Self-checking bench for odd_pipe_result_tracker: directed scenarios plus randomized traffic vs a cycle-indexed model.
module tb_odd_pipe_result_tracker;
   import spu_odd_pkg::*;

   localparam int DW     = 128;
   localparam int AW     = 7;
   localparam int NU     = 3;
   localparam int DP     = 7;
   localparam int MAXLAT = 6;
   localparam int MAXC   = 1024;
   localparam int LAT [NU] = '{4, 6, 1};
   localparam logic [DW-1:0] PERM_DATA = 128'h5A7F_0123_4567_89AB_CDEF_0011_2233_44E2;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               issue_valid = 1'b0;
   logic [1:0]         issue_unit = '0;
   logic [AW-1:0]      issue_addr = '0;
   logic               issue_wr = 1'b0;
   logic               issue_kill = 1'b0;
   logic [NU-1:0]      res_valid = '0;
   logic [NU*DW-1:0]   res_data = '0;
   logic               wb_valid;
   logic [DW-1:0]      wb_data;
   logic [AW-1:0]      wb_reg_addr;
   logic               wb_enable_reg_write;
   logic [DP-1:0]      fwd_valid;
   logic [DP-1:0]      fwd_ready;
   logic [DP-1:0]      fwd_wr;
   logic [DP*AW-1:0]   fwd_addr;
   logic [DP*DW-1:0]   fwd_data;
   logic               proto_err;

   always #5 clock = ~clock;

   odd_pipe_result_tracker #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_UNITS(NU), .DEPTH(DP), .LAT(LAT)
   ) dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_addr(issue_addr),
      .issue_wr(issue_wr), .issue_kill(issue_kill),
      .res_valid(res_valid), .res_data(res_data),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg_addr(wb_reg_addr),
      .wb_enable_reg_write(wb_enable_reg_write),
      .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_wr(fwd_wr),
      .fwd_addr(fwd_addr), .fwd_data(fwd_data), .proto_err(proto_err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: what was driven in each cycle since the last reset
   logic          m_iv   [MAXC];
   int            m_unit [MAXC];
   logic [AW-1:0] m_addr [MAXC];
   logic          m_wr   [MAXC];
   logic          m_kill [MAXC];
   logic [NU-1:0] m_rv   [MAXC];
   logic [DW-1:0] m_rd   [MAXC][NU];
   logic          exp_err = 1'b0;

   // Inputs for the next cycle
   logic          n_iv = 1'b0, n_wr = 1'b0, n_kill = 1'b0;
   logic [1:0]    n_unit = '0;
   logic [AW-1:0] n_addr = '0;
   logic [NU-1:0] n_rv = '0;
   logic [DW-1:0] n_rd [NU];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected state at cycle cyc: stage s holds the issue from cycle cyc-s
   task automatic check_model();
      logic [DP-1:0]    ev, er, ew;
      logic [DP*AW-1:0] ea;
      logic [DW-1:0]    ed [DP];
      int e, u, l;
      ev = '0; er = '0; ew = '0; ea = '0;
      for (int s = 1; s <= DP; s++) begin
         ed[s-1] = '0;
         e = cyc - s;
         if (e >= 0 && m_iv[e]) begin
            u = m_unit[e];
            l = LAT[u];
            ev[s-1] = 1'b1;
            ea[(s-1)*AW +: AW] = m_addr[e];
            if (s <= l) begin
               ew[s-1] = m_wr[e] & ~m_kill[e];
            end else begin
               er[s-1] = 1'b1;
               if (m_rv[e+l][u]) begin
                  ed[s-1] = m_rd[e+l][u];
                  ew[s-1] = m_wr[e] & ~m_kill[e];
               end
            end
         end
      end
      chk("fwd_valid", fwd_valid, ev);
      chk("fwd_ready", fwd_ready, er);
      chk("fwd_wr", fwd_wr, ew);
      chk("fwd_addr", fwd_addr, ea);
      for (int s = 0; s < DP; s++) chk($sformatf("fwd_data_s%0d", s + 1), fwd_data[s*DW +: DW], ed[s]);
      chk("wb_valid", wb_valid, ev[DP-1]);
      chk("wb_reg_addr", wb_reg_addr, ea[(DP-1)*AW +: AW]);
      chk("wb_data", wb_data, ed[DP-1]);
      chk("wb_enable", wb_enable_reg_write, ev[DP-1] & er[DP-1] & ew[DP-1]);
      chk("proto_err", proto_err, exp_err);
   endtask

   // One clock cycle: check state, drive and record inputs, advance
   task automatic step();
      logic nerr;
      int e;
      logic occ;
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: observed=%0d expected<%0d", cyc, MAXC);
         $fatal(1);
      end
      @(negedge clock);
      check_model();
      reset       = 1'b0;
      issue_valid = n_iv;
      issue_unit  = n_unit;
      issue_addr  = n_addr;
      issue_wr    = n_wr;
      issue_kill  = n_kill;
      res_valid   = n_rv;
      res_data    = {n_rd[2], n_rd[1], n_rd[0]};
      m_iv[cyc] = n_iv; m_unit[cyc] = int'(n_unit); m_addr[cyc] = n_addr;
      m_wr[cyc] = n_wr; m_kill[cyc] = n_kill; m_rv[cyc] = n_rv;
      for (int u = 0; u < NU; u++) m_rd[cyc][u] = n_rd[u];
      // A result is expected exactly when an issue to that unit is LAT cycles old
      nerr = exp_err;
      for (int u = 0; u < NU; u++) begin
         e   = cyc - LAT[u];
         occ = (e >= 0) && m_iv[e] && (m_unit[e] == u);
         if (n_rv[u] && !occ && cyc >= MAXLAT) nerr = 1'b1;
         if (!n_rv[u] && occ) nerr = 1'b1;
      end
      @(posedge clock);
      exp_err = nerr;
      cyc++;
      n_iv = 1'b0; n_wr = 1'b0; n_kill = 1'b0; n_unit = '0; n_addr = '0; n_rv = '0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset       = 1'b1;
      issue_valid = 1'b0;
      issue_kill  = 1'b0;
      res_valid   = '1;
      res_data    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      repeat (2) @(posedge clock);
      cyc     = 0;
      exp_err = 1'b0;
   endtask

   task automatic rand_issue();
      n_iv   = ($urandom_range(99) < 60);
      n_unit = 2'($urandom_range(2));
      n_addr = AW'($urandom);
      n_wr   = 1'($urandom);
      n_kill = ($urandom_range(9) == 0);
   endtask

   // Present due results (dropped with drop_pct), plus stray ones with spur_pct
   task automatic plan_results(input int drop_pct, input int spur_pct);
      int e;
      logic occ;
      for (int u = 0; u < NU; u++) begin
         e    = cyc - LAT[u];
         occ  = (e >= 0) && m_iv[e] && (m_unit[e] == u);
         n_rv[u] = occ ? ($urandom_range(99) >= drop_pct) : ($urandom_range(99) < spur_pct);
         n_rd[u] = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   initial begin
      for (int u = 0; u < NU; u++) n_rd[u] = '0;

      // Reset with all result strobes high
      do_reset();
      #1;
      chk("reset_wb_valid", wb_valid, 1'b0);
      chk("reset_wb_enable", wb_enable_reg_write, 1'b0);
      chk("reset_wb_data", wb_data, '0);
      chk("reset_fwd_valid", fwd_valid, '0);
      chk("reset_proto_err", proto_err, 1'b0);
      repeat (8) step();

      // Single permute
      n_iv = 1'b1; n_unit = UNIT_PERM; n_addr = 7'd3; n_wr = 1'b1; step();
      repeat (3) step();
      n_rv = 3'b001; n_rd[0] = PERM_DATA; step();
      #1 chk("perm_ready_s5", fwd_ready[4], 1'b1);
      repeat (2) step();
      #1;
      chk("perm_wb_en", wb_enable_reg_write, 1'b1);
      chk("perm_wb_addr", wb_reg_addr, 7'd3);
      chk("perm_wb_data", wb_data, PERM_DATA);

      // Back-to-back local store, permute, branch
      n_iv = 1'b1; n_unit = UNIT_LS;   n_addr = 7'd6; n_wr = 1'b1; step();
      n_iv = 1'b1; n_unit = UNIT_PERM; n_addr = 7'd5; n_wr = 1'b1; step();
      n_iv = 1'b1; n_unit = UNIT_BR;   n_addr = 7'd0; n_wr = 1'b0; step();
      n_rv = 3'b100; n_rd[2] = 128'hB;          step();
      step();
      n_rv = 3'b001; n_rd[0] = 128'h5555_0005; step();
      n_rv = 3'b010; n_rd[1] = 128'h6666_0006; step();
      #1;
      chk("b2b_ls_en", wb_enable_reg_write, 1'b1);
      chk("b2b_ls_addr", wb_reg_addr, 7'd6);
      chk("b2b_ls_data", wb_data, 128'h6666_0006);
      step();
      #1;
      chk("b2b_perm_en", wb_enable_reg_write, 1'b1);
      chk("b2b_perm_addr", wb_reg_addr, 7'd5);
      chk("b2b_perm_data", wb_data, 128'h5555_0005);
      step();
      #1;
      chk("b2b_br_valid", wb_valid, 1'b1);
      chk("b2b_br_en", wb_enable_reg_write, 1'b0);

      // Killed permute still absorbs its result
      n_iv = 1'b1; n_unit = UNIT_PERM; n_addr = 7'd9; n_wr = 1'b1; n_kill = 1'b1; step();
      repeat (3) step();
      n_rv = 3'b001; n_rd[0] = 128'h9; step();
      repeat (2) step();
      #1;
      chk("kill_wb_valid", wb_valid, 1'b1);
      chk("kill_wb_en", wb_enable_reg_write, 1'b0);
      chk("kill_proto_err", proto_err, 1'b0);

      // Local store whose result never comes
      n_iv = 1'b1; n_unit = UNIT_LS; n_addr = 7'd4; n_wr = 1'b1; step();
      repeat (5) step();
      #1 chk("missing_pre_err", proto_err, 1'b0);
      step();
      #1;
      chk("missing_err", proto_err, 1'b1);
      chk("missing_wb_valid", wb_valid, 1'b1);
      chk("missing_wb_en", wb_enable_reg_write, 1'b0);
      repeat (5) step();
      #1 chk("missing_err_sticky", proto_err, 1'b1);

      // Guard window, then a stray local-store result
      do_reset();
      #1 chk("reset_clears_err", proto_err, 1'b0);
      step();
      n_rv = 3'b111; step();
      repeat (18) step();
      #1 chk("guard_silent", proto_err, 1'b0);
      n_rv = 3'b010; n_rd[1] = 128'hDEAD; step();
      #1 chk("stray_err", proto_err, 1'b1);
      repeat (10) step();
      #1 chk("stray_err_hold", proto_err, 1'b0 | 1'b1);

      // Clean random traffic, then traffic with dropped and stray results
      do_reset();
      repeat (400) begin rand_issue(); plan_results(0, 0); step(); end
      #1 chk("clean_traffic_err", proto_err, 1'b0);
      repeat (250) begin rand_issue(); plan_results(5, 2); step(); end

      // Reset with traffic in flight: nothing may write back afterwards
      repeat (20) begin rand_issue(); plan_results(0, 0); step(); end
      do_reset();
      repeat (10) step();
      #1 chk("post_reset_wb_valid", wb_valid, 1'b0);
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
